// File: rtl/stack_bus_pkg.sv
`default_nettype none
// ============================================================================
// stack_bus_pkg : shared word width, responder states and bus constants
// Rev 1.0
// ============================================================================
package stack_bus_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stack_imem_responder_if.sv
`default_nettype none
// ============================================================================
// stack_imem_responder_if : CPU read bus plus loader write port
// Rev 1.0
// ============================================================================
interface stack_imem_responder_if #(
  parameter int AW = 15
);
  import stack_bus_pkg::*;

  logic              req;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              ld_valid;
  logic [AW-1:0]     ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic              ld_ready;
  logic              busy;

  modport master (
    output req, addr, ld_valid, ld_addr, ld_data,
    input  rdata, ack, err, ld_ready, busy
  );

  modport slave (
    input  req, addr, ld_valid, ld_addr, ld_data,
    output rdata, ack, err, ld_ready, busy
  );

endinterface
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// ============================================================================
// stack_ram : single-port DEPTH x WIDTH RAM, write enable, registered read
// Rev 1.0
// ============================================================================
module stack_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array has no reset so it maps onto block RAM; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/stack_imem_responder.sv
`default_nettype none
// ============================================================================
// stack_imem_responder : wait-stated req/ack word-read responder with loader
// Rev 1.0
// ============================================================================
module stack_imem_responder
  import stack_bus_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter int AW          = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  stack_imem_responder_if.slave bus
);

  localparam int            RAW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [3:0]    WAIT_INIT = 4'(WAIT_STATES);

  state_e            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [AW-1:0]     addr_q, addr_nxt, rd_addr;
  logic              oor_q, oor_nxt, rd_oor, ld_oor, ld_accept;
  logic              ram_we, ram_re;
  logic [RAW-1:0]    ram_addr;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_msb;

  // The read launched from IDLE (zero wait states) must use the live bus address.
  assign rd_addr         = (state == IDLE) ? bus.addr[AW-1:0] : addr_q;
  assign rd_oor          = {1'b0, rd_addr} >= DEPTH_LIM;
  assign ld_oor          = {1'b0, bus.ld_addr} >= DEPTH_LIM;
  assign unused_addr_msb = bus.addr[WORD_W-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    oor_nxt   = oor_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = rd_addr[RAW-1:0];
    ld_accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ld_valid) begin
          ld_accept = 1'b1;
          ram_addr  = bus.ld_addr[RAW-1:0];
          ram_we    = !ld_oor;
        end else if (bus.req) begin
          addr_nxt = bus.addr[AW-1:0];
          cnt_nxt  = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
            ram_re    = 1'b1;
            oor_nxt   = rd_oor;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          ram_re    = 1'b1;
          oor_nxt   = rd_oor;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      oor_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      oor_q  <= oor_nxt;
    end
  end

  stack_ram #(
    .DEPTH (DEPTH),
    .AW    (RAW),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.ld_data),
    .rdata (ram_rdata)
  );

  assign bus.ack      = (state == RESP);
  assign bus.err      = (state == RESP) && oor_q;
  assign bus.rdata    = oor_q ? NOP_WORD : ram_rdata;
  assign bus.busy     = (state != IDLE);
  assign bus.ld_ready = ld_accept && rst_n;

endmodule
`default_nettype wire

// File: tb/tb_stack_imem_responder.sv
`default_nettype none
// ============================================================================
// tb_stack_imem_responder : directed vectors for 0/1/3 wait-state responders
// Rev 1.0
// ============================================================================
module tb_stack_imem_responder;
  import stack_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_imem_responder_if #(.AW(15)) bus0 ();
  stack_imem_responder_if #(.AW(15)) bus1 ();
  stack_imem_responder_if #(.AW(15)) bus3 ();

  stack_imem_responder #(.DEPTH(1024), .WAIT_STATES(0), .AW(15)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  stack_imem_responder #(.DEPTH(1024), .WAIT_STATES(1), .AW(15)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  stack_imem_responder #(.DEPTH(1024), .WAIT_STATES(3), .AW(15)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ld_valid;
    logic [14:0] ld_addr;
    logic [15:0] ld_data;
    logic        req;
    logic [15:0] addr;
    logic        e_ld_ready;
    logic        e_ack;
    logic        e_err;
    logic        e_busy;
    logic [15:0] e_rdata;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic lv, input logic [14:0] la, input logic [15:0] ldat,
                              input logic rq, input logic [15:0] ad, input logic elr,
                              input logic eack, input logic eerr, input logic ebusy,
                              input logic [15:0] erd);
    vec_t v;
    v.ld_valid = lv;  v.ld_addr = la;  v.ld_data = ldat;
    v.req = rq;       v.addr = ad;     v.e_ld_ready = elr;
    v.e_ack = eack;   v.e_err = eerr;  v.e_busy = ebusy;  v.e_rdata = erd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [14:0] a, input logic [15:0] d);
    bus0.ld_valid = 1'b1; bus0.ld_addr = a; bus0.ld_data = d;
    @(negedge clk);
    check("load0_ld_ready", 32'(bus0.ld_ready), 32'd1);
    tick();
    bus0.ld_valid = 1'b0;
  endtask

  task automatic load3(input logic [14:0] a, input logic [15:0] d);
    bus3.ld_valid = 1'b1; bus3.ld_addr = a; bus3.ld_data = d;
    @(negedge clk);
    check("load3_ld_ready", 32'(bus3.ld_ready), 32'd1);
    tick();
    bus3.ld_valid = 1'b0;
  endtask

  int lat;
  bit found;
  int ack_seen;

  initial begin
    bus0.req = 0; bus0.addr = 0; bus0.ld_valid = 0; bus0.ld_addr = 0; bus0.ld_data = 0;
    bus1.req = 0; bus1.addr = 0; bus1.ld_valid = 0; bus1.ld_addr = 0; bus1.ld_data = 0;
    bus3.req = 0; bus3.addr = 0; bus3.ld_valid = 0; bus3.ld_addr = 0; bus3.ld_data = 0;

    // lv  ld_addr   ld_data   req addr       ldr ack err busy rdata
    vecs[0]  = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[1]  = mk(1, 15'h0000, 16'h8005, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[2]  = mk(1, 15'h0001, 16'h0100, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[3]  = mk(1, 15'h0002, 16'h1234, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[4]  = mk(1, 15'h0005, 16'h5555, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[5]  = mk(1, 15'h0400, 16'hBEEF, 0, 16'h0000, 1, 0, 0, 0, 16'h0000);
    vecs[6]  = mk(0, 15'h0000, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[7]  = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);
    vecs[8]  = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 16'h8005);
    vecs[9]  = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h8005);
    vecs[10] = mk(0, 15'h0000, 16'h0000, 1, 16'h0400, 0, 0, 0, 0, 16'h8005);
    vecs[11] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h8005);
    vecs[12] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 16'h0000);
    vecs[13] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[14] = mk(0, 15'h0000, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 16'h0000);
    vecs[15] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h0000);
    vecs[16] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 16'h8005);
    vecs[17] = mk(1, 15'h0003, 16'hA5A5, 1, 16'h0003, 1, 0, 0, 0, 16'h8005);
    vecs[18] = mk(0, 15'h0000, 16'h0000, 1, 16'h0003, 0, 0, 0, 0, 16'h8005);
    vecs[19] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h8005);
    vecs[20] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 16'hA5A5);
    vecs[21] = mk(0, 15'h0000, 16'h0000, 1, 16'h0001, 0, 0, 0, 0, 16'hA5A5);
    vecs[22] = mk(1, 15'h0006, 16'h7777, 0, 16'h0000, 0, 0, 0, 1, 16'hA5A5);
    vecs[23] = mk(1, 15'h0006, 16'h7777, 0, 16'h0000, 0, 1, 0, 1, 16'h0100);
    vecs[24] = mk(1, 15'h0006, 16'h7777, 0, 16'h0000, 1, 0, 0, 0, 16'h0100);
    vecs[25] = mk(0, 15'h0000, 16'h0000, 1, 16'h0006, 0, 0, 0, 0, 16'h0100);
    vecs[26] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h0100);
    vecs[27] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 16'h7777);
    vecs[28] = mk(0, 15'h0000, 16'h0000, 1, 16'h8001, 0, 0, 0, 0, 16'h7777);
    vecs[29] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h7777);
    vecs[30] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 16'h0100);
    vecs[31] = mk(0, 15'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0100);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",      32'({bus0.ack, bus1.ack, bus3.ack}), 32'd0);
    check("rst_err",      32'({bus0.err, bus1.err, bus3.err}), 32'd0);
    check("rst_busy",     32'({bus0.busy, bus1.busy, bus3.busy}), 32'd0);
    check("rst_ld_ready", 32'({bus0.ld_ready, bus1.ld_ready, bus3.ld_ready}), 32'd0);
    check("rst_rdata",    32'(bus1.rdata), 32'h0000);
    rst_n = 1'b1;
    tick();

    // Single-wait-state responder, one vector per cycle
    for (int i = 0; i < NV; i++) begin
      bus1.ld_valid = vecs[i].ld_valid; bus1.ld_addr = vecs[i].ld_addr;
      bus1.ld_data  = vecs[i].ld_data;  bus1.req     = vecs[i].req;
      bus1.addr     = vecs[i].addr;
      @(negedge clk);
      check($sformatf("v%0d_ld_ready", i), 32'(bus1.ld_ready), 32'(vecs[i].e_ld_ready));
      check($sformatf("v%0d_ack", i),      32'(bus1.ack),      32'(vecs[i].e_ack));
      check($sformatf("v%0d_err", i),      32'(bus1.err),      32'(vecs[i].e_err));
      check($sformatf("v%0d_busy", i),     32'(bus1.busy),     32'(vecs[i].e_busy));
      check($sformatf("v%0d_rdata", i),    32'(bus1.rdata),    32'(vecs[i].e_rdata));
      tick();
    end

    // Zero wait states, back-to-back reads
    load0(15'h0000, 16'h8005);
    load0(15'h0001, 16'h0100);
    bus0.req = 1'b1; bus0.addr = 16'h0000;
    found = 0; lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus0.ack) begin found = 1; lat = k; break; end
      tick();
    end
    check("b2b_ack1_seen", 32'(found), 32'd1);
    check("b2b_ack1_lat", 32'(lat), 32'd1);
    check("b2b_ack1_rdata", 32'(bus0.rdata), 32'h8005);
    check("b2b_ack1_err", 32'(bus0.err), 32'd0);
    bus0.addr = 16'h0001;
    tick();
    found = 0; lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus0.ack) begin found = 1; lat = k + 1; break; end
      tick();
    end
    check("b2b_ack2_seen", 32'(found), 32'd1);
    check("b2b_ack_spacing", 32'(lat), 32'd2);
    check("b2b_ack2_rdata", 32'(bus0.rdata), 32'h0100);
    bus0.req = 1'b0;
    tick();
    @(negedge clk);
    check("b2b_no_third_ack", 32'({bus0.ack, bus0.busy}), 32'd0);
    tick();

    // Three wait states, address changes during WAIT
    load3(15'h0002, 16'h2222);
    load3(15'h0005, 16'h5555);
    bus3.req = 1'b1; bus3.addr = 16'h0002;
    found = 0; lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus3.ack) begin found = 1; lat = k; break; end
      tick();
      bus3.addr = 16'h0005;
    end
    check("w3_ack_seen", 32'(found), 32'd1);
    check("w3_ack_lat", 32'(lat), 32'd4);
    check("w3_rdata_addr_latched", 32'(bus3.rdata), 32'h2222);
    bus3.req = 1'b0;
    tick();

    // Reset during WAIT
    bus3.req = 1'b1; bus3.addr = 16'h0005;
    tick();
    tick();
    check("rstw_busy_before", 32'(bus3.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_ack",   32'(bus3.ack), 32'd0);
    check("rstw_busy",  32'(bus3.busy), 32'd0);
    check("rstw_rdata", 32'({bus3.rdata, bus1.rdata}), 32'h0);
    bus3.req = 1'b0;
    ack_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus3.ack) ack_seen++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus3.ack) ack_seen++;
    end
    check("rstw_no_ack", 32'(ack_seen), 32'd0);
    tick();
    bus3.req = 1'b1; bus3.addr = 16'h0005;
    found = 0; lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus3.ack) begin found = 1; lat = k; break; end
      tick();
    end
    check("post_rst_ack_seen", 32'(found), 32'd1);
    check("post_rst_lat", 32'(lat), 32'd4);
    check("post_rst_rdata", 32'(bus3.rdata), 32'h5555);
    bus3.req = 1'b0;
    tick();

    bus1.req = 1'b1; bus1.addr = 16'h0000;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus1.ack) begin found = 1; break; end
      tick();
    end
    check("post_rst_ws1_seen", 32'(found), 32'd1);
    check("post_rst_ws1_rdata", 32'(bus1.rdata), 32'h8005);
    bus1.req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
